pipe_stage_buf: RTL and testbench

Parametrised, elastic pipeline-stage register for the pipelined CPU datapath. It replaces a fixed single-entry inter-stage latch with a DEPTH-entry circular buffer carrying a WIDTH-bit packed stage bundle, using valid/ready handshakes on both sides. Pipeline control arrives as a pipe_state_t command with NORMAL, STALL and FLUSH modes. A saturating back-pressure counter supports hazard-unit profiling. It sits between any two CPU stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and is instantiated once per stage boundary.

---
 rtl/cpu_types_pkg.sv | 52 +++++
 rtl/pipe_stage_buf_if.sv | 37 +++
 rtl/sat_counter.sv | 27 ++
 rtl/pipe_stage_buf.sv | 99 +++++++++
 tb/tb_pipe_stage_buf.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
//   Shared CPU datapath types. Holds the pipeline-control command used by
//   every inter-stage buffer and the packed per-boundary stage bundles.
//   Stage buffers are sized from these with WIDTH = $bits(<bundle>).
package cpu_types_pkg;

  // Pipeline command from the hazard/control unit. The unused encoding
  // 2'b11 is treated as STALL by consumers, which only test for NORMAL
  // and FLUSH explicitly.
  typedef enum logic [1:0] {
    NORMAL = 2'b00,
    STALL  = 2'b01,
    FLUSH  = 2'b10
  } pipe_state_t;

  // IF/ID boundary bundle.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_bundle_t;

  // ID/EX boundary bundle.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
  } id_ex_bundle_t;

  // EX/MEM boundary bundle.
  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_val;
    logic [4:0]  rd;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
  } ex_mem_bundle_t;

  // MEM/WB boundary bundle.
  typedef struct packed {
    logic [31:0] wb_val;
    logic [4:0]  rd;
    logic        reg_we;
  } mem_wb_bundle_t;

endpackage

// File: rtl/pipe_stage_buf_if.sv
// pipe_stage_buf_if
//   Valid/ready handshake bundle between a producer stage, a stage buffer
//   and a consumer stage.
//   up_valid/up_ready/up_data : producer -> buffer
//   dn_valid/dn_ready/dn_data : buffer -> consumer
//   modport master : the stage side (drives up_*, dn_ready)
//   modport slave  : the buffer side (drives up_ready, dn_valid, dn_data)
interface pipe_stage_buf_if #(
  parameter int WIDTH = 32
);

  logic             up_valid;
  logic             up_ready;
  logic [WIDTH-1:0] up_data;
  logic             dn_valid;
  logic             dn_ready;
  logic [WIDTH-1:0] dn_data;

  modport master (
    output up_valid,
    output up_data,
    output dn_ready,
    input  up_ready,
    input  dn_valid,
    input  dn_data
  );

  modport slave (
    input  up_valid,
    input  up_data,
    input  dn_ready,
    output up_ready,
    output dn_valid,
    output dn_data
  );

endinterface

// File: rtl/sat_counter.sv
// sat_counter
//   W-bit up-counter that stops at its all-ones value instead of wrapping.
//   Cleared only by reset.
//   CLK  : clock, rising edge
//   nRST : synchronous active-low reset
//   inc  : count this cycle
//   cnt  : current count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf
//   Elastic inter-stage register: a DEPTH-entry circular buffer of WIDTH-bit
//   stage bundles with valid/ready on both sides, controlled by a
//   NORMAL/STALL/FLUSH command, plus a saturating back-pressure counter.
//   CLK       : clock, rising edge
//   nRST      : synchronous active-low reset
//   ctrl      : pipeline command (unknown encodings act as STALL)
//   bus       : handshake bundle, slave side (up_* in, dn_* out)
//   occupancy : current number of stored entries (0..DEPTH)
//   bp_cnt    : saturating count of cycles with up_valid=1 and up_ready=0
module pipe_stage_buf
  import cpu_types_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  pipe_state_t            ctrl,
  pipe_stage_buf_if.slave        bus,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [CNT_W-1:0]       bp_cnt
);

  localparam int PTR_W = $clog2(DEPTH);

  // DEPTH is a power of two, so DEPTH fits exactly in PTR_W+1 bits.
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;

  logic is_normal;
  logic is_flush;
  logic enq;
  logic deq;

  assign is_normal = (ctrl == NORMAL);
  assign is_flush  = (ctrl == FLUSH);

  // Full blocks the producer even if the consumer drains this cycle, which
  // keeps dn_ready off the up_ready path. Reset and anything other than
  // NORMAL (STALL, FLUSH, undefined) close both handshakes.
  assign bus.up_ready = nRST & is_normal & (count < FULL_CNT);
  assign bus.dn_valid = nRST & is_normal & (count != '0);

  // Head is always driven straight from storage; there is no bypass from
  // up_data, so an empty buffer never presents valid data.
  assign bus.dn_data = mem[rd_ptr];

  assign enq = bus.up_valid & bus.up_ready;
  assign deq = bus.dn_valid & bus.dn_ready;

  assign occupancy = count;

  // NOTE: the storage array has no reset; entries are only ever observed
  // after being written, and leaving it reset-free lets it map onto RAM.
  always_ff @(posedge CLK) begin
    if (enq) begin
      mem[wr_ptr] <= bus.up_data;
    end
  end

  // Pointers wrap naturally at DEPTH because they are exactly PTR_W bits.
  always_ff @(posedge CLK) begin
    if (!nRST || is_flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Back-pressure: the producer offers but is refused. This includes
  // STALL and FLUSH cycles, since up_ready is low there.
  sat_counter #(
    .W (CNT_W)
  ) u_bp_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (bus.up_valid & ~bus.up_ready),
    .cnt  (bp_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf
//   Self-checking bench for pipe_stage_buf (DEPTH=4, WIDTH=32, CNT_W=4).
//   Accepted bundles are pushed to a scoreboard queue; a monitor on the
//   falling edge pops and compares every delivered head.
module tb_pipe_stage_buf;
  import cpu_types_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int BP_MAX = (1 << CNT_W) - 1;

  logic                   clk;
  logic                   nRST;
  pipe_state_t            ctrl;
  logic [$clog2(DEPTH):0] occupancy;
  logic [CNT_W-1:0]       bp_cnt;

  pipe_stage_buf_if #(.WIDTH(WIDTH)) bus ();

  pipe_stage_buf #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .CLK       (clk),
    .nRST      (nRST),
    .ctrl      (ctrl),
    .bus       (bus),
    .occupancy (occupancy),
    .bp_cnt    (bp_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] sb [$];
  int bp_exp = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Offer one bundle that must be accepted this cycle.
  task automatic push_one(input logic [WIDTH-1:0] d);
    bus.up_valid = 1'b1;
    bus.up_data  = d;
    @(negedge clk);
    check("enq_ready", bus.up_ready, 1);
    sb.push_back(d);
    cyc();
    bus.up_valid = 1'b0;
  endtask

  // Scoreboard monitor: every handshake on the consumer side must match
  // the oldest outstanding accepted bundle.
  always @(negedge clk) begin
    if (nRST === 1'b1 && bus.dn_valid === 1'b1 && bus.dn_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("dn_spurious", 1, 0);
      end else begin
        check("dn_data", bus.dn_data, sb.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST         = 1'b0;
    ctrl         = NORMAL;
    bus.up_valid = 1'b1;
    bus.up_data  = 32'h0;
    bus.dn_ready = 1'b0;

    // Reset held for two edges with a pending producer.
    cyc();
    cyc();
    @(negedge clk);
    check("rst_up_ready", bus.up_ready, 0);
    check("rst_dn_valid", bus.dn_valid, 0);
    check("rst_occ", occupancy, 0);
    check("rst_bp", bp_cnt, 0);
    cyc();
    nRST = 1'b1;
    bus.up_valid = 1'b0;
    @(negedge clk);
    check("rel_up_ready", bus.up_ready, 1);
    check("rel_dn_valid", bus.dn_valid, 0);
    cyc();

    // Fill to full with the consumer blocked, then drain in order.
    for (int i = 0; i < DEPTH; i++) push_one(32'hA0 + i);
    @(negedge clk);
    check("full_occ", occupancy, DEPTH);
    check("full_up_ready", bus.up_ready, 0);
    check("full_dn_valid", bus.dn_valid, 1);
    cyc();
    bus.dn_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      check("drain_valid", bus.dn_valid, 1);
      cyc();
    end
    @(negedge clk);
    check("drain_occ", occupancy, 0);
    check("drain_dn_valid", bus.dn_valid, 0);
    check("drain_sb", sb.size(), 0);
    cyc();

    // Streaming across pointer wrap: one in, one out per cycle.
    for (int i = 0; i < 20; i++) begin
      bus.up_valid = 1'b1;
      bus.up_data  = 32'hB00 + i;
      @(negedge clk);
      check("stream_ready", bus.up_ready, 1);
      if (i > 0) check("stream_occ", occupancy, 1);
      sb.push_back(32'hB00 + i);
      cyc();
    end
    bus.up_valid = 1'b0;
    cyc();
    @(negedge clk);
    check("stream_end_occ", occupancy, 0);
    check("stream_sb", sb.size(), 0);
    cyc();

    // STALL with two entries present.
    bus.dn_ready = 1'b0;
    push_one(32'hC0);
    push_one(32'hC1);
    ctrl         = STALL;
    bus.up_valid = 1'b1;
    bus.up_data  = 32'hDEAD;
    bus.dn_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_dn_valid", bus.dn_valid, 0);
      check("stall_up_ready", bus.up_ready, 0);
      check("stall_occ", occupancy, 2);
      cyc();
      bp_exp++;
    end
    ctrl         = NORMAL;
    bus.up_valid = 1'b0;
    @(negedge clk);
    check("stall_bp", bp_cnt, bp_exp);
    check("unstall_dn_valid", bus.dn_valid, 1);
    check("unstall_head", bus.dn_data, 32'hC0);
    cyc();
    cyc();
    @(negedge clk);
    check("unstall_occ", occupancy, 0);
    check("unstall_sb", sb.size(), 0);
    cyc();

    // FLUSH with the producer and consumer both active at occupancy 3.
    bus.dn_ready = 1'b0;
    push_one(32'hD0);
    push_one(32'hD1);
    push_one(32'hD2);
    @(negedge clk);
    check("preflush_occ", occupancy, 3);
    cyc();
    ctrl         = FLUSH;
    bus.up_valid = 1'b1;
    bus.up_data  = 32'hEE;
    bus.dn_ready = 1'b1;
    @(negedge clk);
    check("flush_up_ready", bus.up_ready, 0);
    check("flush_dn_valid", bus.dn_valid, 0);
    cyc();
    bp_exp++;
    sb.delete();
    ctrl         = NORMAL;
    bus.up_valid = 1'b0;
    @(negedge clk);
    check("postflush_occ", occupancy, 0);
    check("postflush_dn_valid", bus.dn_valid, 0);
    check("postflush_up_ready", bus.up_ready, 1);
    check("postflush_bp", bp_cnt, bp_exp);
    cyc();
    cyc();
    push_one(32'hF0);
    cyc();
    @(negedge clk);
    check("postflush_sb", sb.size(), 0);
    cyc();

    // Saturation: producer refused by a full buffer for 20 cycles.
    bus.dn_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_one(32'h100 + i);
    bus.up_valid = 1'b1;
    bus.up_data  = 32'h1FF;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("sat_up_ready", bus.up_ready, 0);
      check("sat_bp_step", bp_cnt, bp_exp);
      cyc();
      if (bp_exp < BP_MAX) bp_exp++;
    end
    bus.up_valid = 1'b0;
    @(negedge clk);
    check("sat_bp_final", bp_cnt, BP_MAX);
    cyc();
    bus.dn_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) cyc();
    @(negedge clk);
    check("final_occ", occupancy, 0);
    check("final_sb", sb.size(), 0);
    check("final_bp_held", bp_cnt, BP_MAX);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
